perf_counter_unit: RTL and testbench

PERF_COUNTER_UNIT -- requirements
Module: perf_counter_unit

---
 rtl/perf_counter_unit.sv | 134 +++++++++++++
 tb/tb_perf_counter_unit.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/perf_counter_unit.sv
// Performance counter unit: counts cycles, stalls, retired instructions and
// branch prediction outcomes until a halt or a watchdog expiry freezes them,
// and offers a one-cycle-latency readout port for any single counter.
module perf_counter_unit #(
   parameter int WIDTH      = 32,
   parameter int WDOG_LIMIT = 4096
) (
   input  logic             input_clk,
   input  logic             rst,
   input  logic             retire_valid,
   input  logic             stall,
   input  logic             branch_resolved,
   input  logic             branch_mispredict,
   input  logic             hlt_seen,
   input  logic             clr,
   input  logic             rd_req,
   input  logic [2:0]       rd_sel,
   output logic [WIDTH-1:0] cycles_consumed,
   output logic [WIDTH-1:0] StallCount,
   output logic [WIDTH-1:0] RetiredCount,
   output logic [WIDTH-1:0] BranchPredictionCount,
   output logic [WIDTH-1:0] BranchPredictionMissCount,
   output logic             halted,
   output logic             timeout,
   output logic             rd_valid,
   output logic [WIDTH-1:0] rd_data
);

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      HALTED  = 2'd1,
      TIMEOUT = 2'd2
   } state_t;

   localparam logic [WIDTH-1:0] ALL_ONES = '1;
   localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
   localparam logic [63:0]      LIMIT    = 64'(WDOG_LIMIT);

   state_t           r_state;
   logic [WIDTH-1:0] r_cycles;
   logic [WIDTH-1:0] r_stalls;
   logic [WIDTH-1:0] r_retired;
   logic [WIDTH-1:0] r_branches;
   logic [WIDTH-1:0] r_misses;
   logic             r_halted;
   logic             r_timeout;
   logic             r_rdValid;
   logic [WIDTH-1:0] r_rdData;

   logic             w_cycSat;
   logic             w_expire;
   logic             w_missEvent;
   logic [WIDTH-1:0] w_rdMux;

   // Saturating increment: a counter that reaches all-ones stays there.
   function automatic logic [WIDTH-1:0] satInc(input logic [WIDTH-1:0] value,
                                               input logic en);
      return (en && (value != ALL_ONES)) ? value + ONE : value;
   endfunction

   // The watchdog fires on the edge where the cycle count would step onto the
   // limit; a saturated counter can never reach a limit beyond its range.
   assign w_cycSat    = (r_cycles == ALL_ONES);
   assign w_expire    = !w_cycSat && ((64'(r_cycles) + 64'd1) == LIMIT);
   assign w_missEvent = branch_resolved && branch_mispredict;

   // Readout mux over the current (pre-update) counter values.
   always_comb begin
      w_rdMux = '0;
      case (rd_sel)
         3'd0:    w_rdMux = r_cycles;
         3'd1:    w_rdMux = r_stalls;
         3'd2:    w_rdMux = r_retired;
         3'd3:    w_rdMux = r_branches;
         3'd4:    w_rdMux = r_misses;
         default: w_rdMux = '0;
      endcase
   end

   // Run/halt/timeout state machine and the counters it gates; reset beats
   // clear, and clear beats every event including a halt.
   always_ff @(posedge input_clk) begin
      if (rst || clr) begin
         r_state    <= RUN;
         r_halted   <= 1'b0;
         r_timeout  <= 1'b0;
         r_cycles   <= '0;
         r_stalls   <= '0;
         r_retired  <= '0;
         r_branches <= '0;
         r_misses   <= '0;
      end else if (r_state == RUN) begin
         if (hlt_seen) begin
            r_state  <= HALTED;
            r_halted <= 1'b1;
         end else begin
            r_cycles <= satInc(r_cycles, 1'b1);
            if (w_expire) begin
               r_state   <= TIMEOUT;
               r_timeout <= 1'b1;
            end
         end
         r_stalls   <= satInc(r_stalls, stall);
         r_retired  <= satInc(r_retired, retire_valid);
         r_branches <= satInc(r_branches, branch_resolved);
         r_misses   <= satInc(r_misses, w_missEvent);
      end
   end

   // Readout register: captures the selected counter when requested and
   // otherwise keeps the last returned value.
   always_ff @(posedge input_clk) begin
      if (rst) begin
         r_rdValid <= 1'b0;
         r_rdData  <= '0;
      end else begin
         r_rdValid <= rd_req;
         if (rd_req) begin
            r_rdData <= w_rdMux;
         end
      end
   end

   assign cycles_consumed           = r_cycles;
   assign StallCount                = r_stalls;
   assign RetiredCount              = r_retired;
   assign BranchPredictionCount     = r_branches;
   assign BranchPredictionMissCount = r_misses;
   assign halted                    = r_halted;
   assign timeout                   = r_timeout;
   assign rd_valid                  = r_rdValid;
   assign rd_data                   = r_rdData;

endmodule

// File: tb/tb_perf_counter_unit.sv
// Testbench for perf_counter_unit: readout results flow through an expected
// value queue drained by a monitor; live counters are compared directly.
module tb_perf_counter_unit;

   logic input_clk = 1'b0;
   always #5 input_clk = ~input_clk;

   // Main instance (default parameters)
   logic        rst = 1'b1;
   logic        retire_valid = 1'b0, stall = 1'b0, branch_resolved = 1'b0;
   logic        branch_mispredict = 1'b0, hlt_seen = 1'b0, clr = 1'b0;
   logic        rd_req = 1'b0;
   logic [2:0]  rd_sel = 3'd0;
   logic [31:0] cyc, stl, ret, brc, mis, rd_data;
   logic        halted, timeout, rd_valid;

   // Shared inputs for the small-watchdog and narrow-width instances
   logic        sRst = 1'b1, sStall = 1'b0, sHlt = 1'b0;
   logic [7:0]  bCyc, bStl, bRet, bBrc, bMis, bRdData;
   logic        bHalted, bTimeout, bRdValid;
   logic [3:0]  cCyc, cStl, cRet, cBrc, cMis, cRdData;
   logic        cHalted, cTimeout, cRdValid;

   int numChecks = 0;
   int numFails  = 0;
   logic [31:0] expQ[$];

   perf_counter_unit dutA (
      .input_clk(input_clk), .rst(rst), .retire_valid(retire_valid), .stall(stall),
      .branch_resolved(branch_resolved), .branch_mispredict(branch_mispredict),
      .hlt_seen(hlt_seen), .clr(clr), .rd_req(rd_req), .rd_sel(rd_sel),
      .cycles_consumed(cyc), .StallCount(stl), .RetiredCount(ret),
      .BranchPredictionCount(brc), .BranchPredictionMissCount(mis),
      .halted(halted), .timeout(timeout), .rd_valid(rd_valid), .rd_data(rd_data));

   perf_counter_unit #(.WIDTH(8), .WDOG_LIMIT(16)) dutB (
      .input_clk(input_clk), .rst(sRst), .retire_valid(1'b0), .stall(sStall),
      .branch_resolved(1'b0), .branch_mispredict(1'b0),
      .hlt_seen(sHlt), .clr(1'b0), .rd_req(1'b0), .rd_sel(3'd0),
      .cycles_consumed(bCyc), .StallCount(bStl), .RetiredCount(bRet),
      .BranchPredictionCount(bBrc), .BranchPredictionMissCount(bMis),
      .halted(bHalted), .timeout(bTimeout), .rd_valid(bRdValid), .rd_data(bRdData));

   perf_counter_unit #(.WIDTH(4)) dutC (
      .input_clk(input_clk), .rst(sRst), .retire_valid(1'b0), .stall(sStall),
      .branch_resolved(1'b0), .branch_mispredict(1'b0),
      .hlt_seen(sHlt), .clr(1'b0), .rd_req(1'b0), .rd_sel(3'd0),
      .cycles_consumed(cCyc), .StallCount(cStl), .RetiredCount(cRet),
      .BranchPredictionCount(cBrc), .BranchPredictionMissCount(cMis),
      .halted(cHalted), .timeout(cTimeout), .rd_valid(cRdValid), .rd_data(cRdData));

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      numChecks++;
      if (act !== exp) begin
         numFails++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge input_clk);
      #1;
   endtask

   // Drive one cycle of main-instance inputs; a read queues its expected data.
   task automatic applyStimulus(input logic rv, input logic st, input logic br,
                                input logic bm, input logic hl, input logic cl,
                                input logic rq, input logic [2:0] sel,
                                input logic [31:0] expRd);
      retire_valid      = rv;
      stall             = st;
      branch_resolved   = br;
      branch_mispredict = bm;
      hlt_seen          = hl;
      clr               = cl;
      rd_req            = rq;
      rd_sel            = sel;
      if (rq) expQ.push_back(expRd);
      tick();
   endtask

   task automatic checkCounters(input string tag, input logic [31:0] eCyc, input logic [31:0] eStl,
                                input logic [31:0] eRet, input logic [31:0] eBrc,
                                input logic [31:0] eMis, input logic eHalt, input logic eTo);
      checkOutput({tag, " cycles"}, cyc, eCyc);
      checkOutput({tag, " stalls"}, stl, eStl);
      checkOutput({tag, " retired"}, ret, eRet);
      checkOutput({tag, " branches"}, brc, eBrc);
      checkOutput({tag, " misses"}, mis, eMis);
      checkOutput({tag, " halted"}, 32'(halted), 32'(eHalt));
      checkOutput({tag, " timeout"}, 32'(timeout), 32'(eTo));
   endtask

   // Monitor: every rd_valid must match the oldest queued expectation.
   initial begin
      forever begin
         @(posedge input_clk);
         #2;
         if (rd_valid === 1'b1) begin
            if (expQ.size() == 0) begin
               numChecks++;
               numFails++;
               $display("[TB] FAIL rd_valid unexpected: got rd_data %0d, expected no read", rd_data);
            end else begin
               checkOutput("rd_data", rd_data, expQ.pop_front());
            end
         end else if (rd_valid !== 1'b0) begin
            numChecks++;
            numFails++;
            $display("[TB] FAIL rd_valid unknown: got %b, expected 0 or 1", rd_valid);
         end
      end
   end

   initial begin
      // Reset with read, clear and stall asserted: all must be ignored
      rd_req = 1'b1; clr = 1'b1; stall = 1'b1;
      repeat (2) tick();
      rst = 1'b0; rd_req = 1'b0; clr = 1'b0; stall = 1'b0;
      checkCounters("reset", 0, 0, 0, 0, 0, 1'b0, 1'b0);
      checkOutput("reset rd_valid", 32'(rd_valid), 0);
      checkOutput("reset rd_data", rd_data, 0);

      // Ten idle cycles, then back-to-back reads including unused selects
      repeat (10) applyStimulus(0, 0, 0, 0, 0, 0, 0, 3'd0, 0);
      checkCounters("idle10", 10, 0, 0, 0, 0, 1'b0, 1'b0);
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 3'd0, 32'd10);
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 3'd1, 32'd0);
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 3'd2, 32'd0);
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 3'd3, 32'd0);
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 3'd4, 32'd0);
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 3'd5, 32'd0);
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 3'd7, 32'd0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 3'd0, 0);
      checkOutput("idle cycles after reads", cyc, 32'd18);

      // Clear with every event and halt asserted: events are discarded
      applyStimulus(1, 1, 1, 1, 1, 1, 0, 3'd0, 0);
      checkCounters("clear", 0, 0, 0, 0, 0, 1'b0, 1'b0);

      // Twenty event cycles, then halt
      for (int i = 0; i < 20; i++) begin
         applyStimulus(i >= 5, i < 5, i < 6, (i < 2) || (i == 10), 0, 0, 0, 3'd0, 0);
      end
      applyStimulus(0, 0, 0, 0, 1, 0, 0, 3'd0, 0);
      checkCounters("halt", 20, 5, 15, 6, 2, 1'b1, 1'b0);

      // In HALTED: events ignored, reads still served back-to-back
      applyStimulus(1, 1, 1, 1, 1, 0, 1, 3'd3, 32'd6);
      applyStimulus(1, 1, 1, 1, 1, 0, 1, 3'd4, 32'd2);
      applyStimulus(1, 1, 1, 1, 0, 0, 1, 3'd0, 32'd20);
      checkCounters("halted hold", 20, 5, 15, 6, 2, 1'b1, 1'b0);

      // Clear together with a read returns the pre-clear stall count
      applyStimulus(0, 0, 0, 0, 0, 1, 1, 3'd1, 32'd5);
      checkCounters("clear from halt", 0, 0, 0, 0, 0, 1'b0, 1'b0);
      repeat (3) applyStimulus(0, 0, 0, 0, 0, 0, 0, 3'd0, 0);
      checkOutput("counting after clear", cyc, 32'd3);

      // Mid-run reset with events and a read request pending
      repeat (2) applyStimulus(1, 1, 1, 1, 0, 0, 0, 3'd0, 0);
      checkCounters("pre-reset", 5, 2, 2, 2, 2, 1'b0, 1'b0);
      rst = 1'b1; rd_req = 1'b1; rd_sel = 3'd0;
      tick();
      rst = 1'b0; rd_req = 1'b0;
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 3'd0, 0);
      checkCounters("mid-run reset", 1, 0, 0, 0, 0, 1'b0, 1'b0);
      checkOutput("mid-run reset rd_data", rd_data, 0);

      // Watchdog and saturation: stall held from reset release
      sStall = 1'b1;
      tick();
      sRst = 1'b0;
      repeat (16) tick();
      checkOutput("wdog timeout", 32'(bTimeout), 1);
      checkOutput("wdog halted", 32'(bHalted), 0);
      checkOutput("wdog cycles", 32'(bCyc), 16);
      checkOutput("wdog stalls", 32'(bStl), 16);
      checkOutput("narrow cycles sat", 32'(cCyc), 15);
      checkOutput("narrow timeout", 32'(cTimeout), 0);
      repeat (10) tick();
      checkOutput("wdog cycles hold", 32'(bCyc), 16);
      checkOutput("wdog stalls hold", 32'(bStl), 16);
      checkOutput("wdog timeout hold", 32'(bTimeout), 1);
      checkOutput("narrow stalls sat", 32'(cStl), 15);

      // Reset out of TIMEOUT, then halt on the would-be expiry cycle
      sStall = 1'b0;
      sRst = 1'b1;
      tick();
      sRst = 1'b0;
      checkOutput("wdog reset timeout", 32'(bTimeout), 0);
      checkOutput("wdog reset cycles", 32'(bCyc), 0);
      repeat (15) tick();
      sHlt = 1'b1;
      tick();
      sHlt = 1'b0;
      repeat (3) tick();
      checkOutput("expiry-halt halted", 32'(bHalted), 1);
      checkOutput("expiry-halt timeout", 32'(bTimeout), 0);
      checkOutput("expiry-halt cycles", 32'(bCyc), 15);
      checkOutput("narrow halted", 32'(cHalted), 1);

      repeat (2) tick();
      checkOutput("scoreboard drained", 32'(expQ.size()), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
      $finish;
   end

endmodule
